// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster generator: free-running pixel/line counters, video_on,
// delayed hsync/vsync aligned to the renderer's RGB register, and frame strobes.
module vga_timing_gen #(
  parameter int H_VIDEO     = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VIDEO     = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SYNC_ACTIVE = 0,
  parameter int SYNC_DELAY  = 1
) (
  input  logic       clk_0,
  input  logic       rst,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       vblank_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VIDEO + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIDEO + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VID      = 11'(H_VIDEO);
  localparam logic [10:0] V_VID      = 11'(V_VIDEO);
  localparam logic [10:0] H_SYNC_ON  = 11'(H_VIDEO + H_FP);
  localparam logic [10:0] H_SYNC_OFF = 11'(H_VIDEO + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_ON  = 11'(V_VIDEO + V_FP);
  localparam logic [10:0] V_SYNC_OFF = 11'(V_VIDEO + V_FP + V_SYNC);

  localparam logic SYNC_ON  = (SYNC_ACTIVE != 0) ? 1'b1 : 1'b0;
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic [9:0]  next_x_s;
  logic [9:0]  next_y_s;
  logic        hs_next_s;
  logic        vs_next_s;
  logic        first_seen_r;
  logic [SYNC_DELAY:0] hs_pipe_r;
  logic [SYNC_DELAY:0] vs_pipe_r;

  // Next raster position: x wraps at end of line, y advances only on that wrap.
  always_comb begin
    next_x_s = pixel_x + 10'd1;
    next_y_s = pixel_y;
    if (pixel_x == H_LAST) begin
      next_x_s = 10'd0;
      if (pixel_y == V_LAST) begin
        next_y_s = 10'd0;
      end else begin
        next_y_s = pixel_y + 10'd1;
      end
    end else begin
      next_x_s = pixel_x + 10'd1;
      next_y_s = pixel_y;
    end
  end

  // Sync decode on the next count so stage 0 registers the raw sync of the current count.
  always_comb begin
    hs_next_s = SYNC_OFF;
    vs_next_s = SYNC_OFF;
    if (({1'b0, next_x_s} >= H_SYNC_ON) && ({1'b0, next_x_s} < H_SYNC_OFF)) begin
      hs_next_s = SYNC_ON;
    end else begin
      hs_next_s = SYNC_OFF;
    end
    if (({1'b0, next_y_s} >= V_SYNC_ON) && ({1'b0, next_y_s} < V_SYNC_OFF)) begin
      vs_next_s = SYNC_ON;
    end else begin
      vs_next_s = SYNC_OFF;
    end
  end

  // Raster counters and the strobes describing the position being loaded.
  always_ff @(posedge clk_0) begin
    if (!rst) begin
      pixel_x      <= H_LAST;
      pixel_y      <= V_LAST;
      video_on     <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      pixel_x      <= next_x_s;
      pixel_y      <= next_y_s;
      video_on     <= ({1'b0, next_x_s} < H_VID) && ({1'b0, next_y_s} < V_VID);
      frame_start  <= (next_x_s == 10'd0) && (next_y_s == 10'd0);
      vblank_start <= (next_x_s == 10'd0) && ({1'b0, next_y_s} == V_VID);
    end
  end

  // Frame counter; the frame begun by reset release is frame 0 and is not counted.
  always_ff @(posedge clk_0) begin
    if (!rst) begin
      frame_count  <= 8'd0;
      first_seen_r <= 1'b0;
    end else if ((next_x_s == 10'd0) && (next_y_s == 10'd0)) begin
      first_seen_r <= 1'b1;
      if (first_seen_r) begin
        frame_count <= frame_count + 8'd1;
      end else begin
        frame_count <= frame_count;
      end
    end else begin
      frame_count  <= frame_count;
      first_seen_r <= first_seen_r;
    end
  end

  // Sync delay line; stage k holds the raw sync of the count k clocks ago.
  always_ff @(posedge clk_0) begin
    if (!rst) begin
      hs_pipe_r <= {(SYNC_DELAY + 1){SYNC_OFF}};
      vs_pipe_r <= {(SYNC_DELAY + 1){SYNC_OFF}};
    end else begin
      hs_pipe_r[0] <= hs_next_s;
      vs_pipe_r[0] <= vs_next_s;
      for (int k = 1; k <= SYNC_DELAY; k++) begin
        hs_pipe_r[k] <= hs_pipe_r[k-1];
        vs_pipe_r[k] <= vs_pipe_r[k-1];
      end
    end
  end

  assign hsync = hs_pipe_r[SYNC_DELAY];
  assign vsync = vs_pipe_r[SYNC_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: one full-size instance plus two shrunken 14x7 instances
// (sync delay 3 and 0), all compared every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  logic clk_0 = 1'b0;
  logic rst   = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   n     = -1;

  always #5 clk_0 = ~clk_0;

  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic       a_von, a_hs, a_vs, a_fs, a_vb;
  logic       b_von, b_hs, b_vs, b_fs, b_vb;
  logic       c_von, c_hs, c_vs, c_fs, c_vb;
  logic [7:0] a_fc, b_fc, c_fc;

  vga_timing_gen dut_a (
    .clk_0(clk_0), .rst(rst), .pixel_x(a_x), .pixel_y(a_y), .video_on(a_von),
    .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs), .vblank_start(a_vb),
    .frame_count(a_fc)
  );

  vga_timing_gen #(
    .H_VIDEO(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VIDEO(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_ACTIVE(0), .SYNC_DELAY(3)
  ) dut_b (
    .clk_0(clk_0), .rst(rst), .pixel_x(b_x), .pixel_y(b_y), .video_on(b_von),
    .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs), .vblank_start(b_vb),
    .frame_count(b_fc)
  );

  vga_timing_gen #(
    .H_VIDEO(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VIDEO(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_ACTIVE(0), .SYNC_DELAY(0)
  ) dut_c (
    .clk_0(clk_0), .rst(rst), .pixel_x(c_x), .pixel_y(c_y), .video_on(c_von),
    .hsync(c_hs), .vsync(c_vs), .frame_start(c_fs), .vblank_start(c_vb),
    .frame_count(c_fc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d (cycle %0d after release)", tag, got, exp, n);
    end
  endtask

  // Expected outputs come from n, the number of clocks since reset release
  // (n = -1 while in reset): raster position is n modulo line/frame length.
  task automatic check_dut(input string nm,
                           input int hv, input int hf, input int hs, input int hb,
                           input int vv, input int vf, input int vs, input int vb,
                           input int d,
                           input logic [9:0] px, input logic [9:0] py,
                           input logic von, input logic hsy, input logic vsy,
                           input logic fs, input logic vbs, input logic [7:0] fc);
    int ht, vt, ex, ey, ev, efs, evb, efc, eh, evs, m, xm, ym;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    if (n < 0) begin
      ex = ht - 1; ey = vt - 1; ev = 0; efs = 0; evb = 0; efc = 0;
    end else begin
      ex  = n % ht;
      ey  = (n / ht) % vt;
      ev  = (ex < hv && ey < vv) ? 1 : 0;
      efs = (ex == 0 && ey == 0) ? 1 : 0;
      evb = (ex == 0 && ey == vv) ? 1 : 0;
      efc = (n / (ht * vt)) % 256;
    end
    m = n - d;
    if (n < 0 || m < 0) begin
      eh = 1; evs = 1;
    end else begin
      xm  = m % ht;
      ym  = (m / ht) % vt;
      eh  = (xm >= hv + hf && xm < hv + hf + hs) ? 0 : 1;
      evs = (ym >= vv + vf && ym < vv + vf + vs) ? 0 : 1;
    end
    chk({nm, ".pixel_x"}, {22'd0, px}, ex);
    chk({nm, ".pixel_y"}, {22'd0, py}, ey);
    chk({nm, ".video_on"}, {31'd0, von}, ev);
    chk({nm, ".hsync"}, {31'd0, hsy}, eh);
    chk({nm, ".vsync"}, {31'd0, vsy}, evs);
    chk({nm, ".frame_start"}, {31'd0, fs}, efs);
    chk({nm, ".vblank_start"}, {31'd0, vbs}, evb);
    chk({nm, ".frame_count"}, {24'd0, fc}, efc);
  endtask

  task automatic step(input logic r);
    rst = r;
    @(posedge clk_0);
    if (r == 1'b0) n = -1;
    else n = n + 1;
    @(negedge clk_0);
    check_dut("A", 640, 16, 96, 48, 480, 10, 2, 33, 1,
              a_x, a_y, a_von, a_hs, a_vs, a_fs, a_vb, a_fc);
    check_dut("B", 8, 2, 2, 2, 4, 1, 1, 1, 3,
              b_x, b_y, b_von, b_hs, b_vs, b_fs, b_vb, b_fc);
    check_dut("C", 8, 2, 2, 2, 4, 1, 1, 1, 0,
              c_x, c_y, c_von, c_hs, c_vs, c_fs, c_vb, c_fc);
  endtask

  initial begin
    // Reset held for five clocks, then two full-size lines plus margin.
    repeat (5) step(1'b0);
    repeat (2 * 800 + 10) step(1'b1);

    // Random run lengths interrupted by short random resets mid-line/mid-frame.
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(20, 1500)) step(1'b1);
      repeat ($urandom_range(1, 3)) step(1'b0);
    end

    // Long run: the 14x7 instances pass 256 frames, so frame_count wraps 255->0.
    repeat (25300) step(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates the 640x480@60 VGA raster that the pong renderer consumes. It free-runs horizontal and vertical counters on clk_0 (25.175 MHz) and drives pixel_x, pixel_y and video_on to the renderer. It drives hsync and vsync to the DAC/connector, delayed so they align with the renderer's registered RGB. It also emits frame and vblank strobes and a frame counter for the game logic.

Parameters:
H_VIDEO, 640, active pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_VIDEO, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)
SYNC_DELAY, 1, pipeline stages on hsync/vsync only (legal 0..3)

Ports:
clk_0  in  1  pixel clock, 25.175 MHz
rst  in  1  reset, synchronous, active-low
pixel_x  out  10  horizontal count, 0..H_TOTAL-1
pixel_y  out  10  vertical count, 0..V_TOTAL-1
video_on  out  1  high when pixel_x<H_VIDEO and pixel_y<V_VIDEO
hsync  out  1  horizontal sync, SYNC_DELAY-delayed
vsync  out  1  vertical sync, SYNC_DELAY-delayed
frame_start  out  1  one-cycle pulse coincident with (0,0)
vblank_start  out  1  one-cycle pulse coincident with (0,V_VIDEO)
frame_count  out  8  frames started since reset, wraps 255->0

Behaviour:
- Derived totals: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525). Both totals must be ≤1024; 10-bit counters.
- All outputs are registered. pixel_x and pixel_y are the counter registers. video_on, frame_start and vblank_start are registered from the next-count values, so they are coincident with the pixel_x/pixel_y they describe.
- Reset (rst=0 at a clock edge):
  - pixel_x=H_TOTAL-1 (799), pixel_y=V_TOTAL-1 (524).
  - video_on=0, frame_start=0, vblank_start=0, frame_count=0.
  - hsync, vsync and every delay stage are forced to the inactive level (1 for SYNC_ACTIVE=0).
  - Reset overrides everything, including reset asserted mid-line or mid-frame.
- First edge after release: pixel_x=0, pixel_y=0, video_on=1, frame_start=1. frame_count stays 0 on this first frame; see the frame_count rule below.
- Horizontal counting:
  - pixel_x increments by 1 each clock.
  - At H_TOTAL-1 it wraps to 0 and pixel_y advances.
- Vertical counting:
  - pixel_y increments only on the horizontal wrap.
  - At V_TOTAL-1 with pixel_x=H_TOTAL-1, both counters wrap to 0 on the same edge.
- Raw sync decode, from the current counters:
  - hsync_raw is asserted for H_VIDEO+H_FP ≤ pixel_x < H_VIDEO+H_FP+H_SYNC (656..751).
  - vsync_raw is asserted for V_VIDEO+V_FP ≤ pixel_y < V_VIDEO+V_FP+V_SYNC (490..491), for the full line including blanking.
- Sync delay pipeline:
  - hsync/vsync equal hsync_raw/vsync_raw delayed by SYNC_DELAY clocks.
  - SYNC_DELAY=0 gives combinational decode from the counter registers. Still glitch-free: decode is a compare against registered values feeding an output flop where legal.
  - The default of 1 matches the renderer's one-cycle RGB register.
  - video_on is NOT delayed.
- frame_start: high exactly one cycle per frame, when pixel_x=0 and pixel_y=0.
- vblank_start: high exactly one cycle per frame, when pixel_x=0 and pixel_y=V_VIDEO. This is the game-logic update window.
- frame_count: increments by 1 on the edge that produces each frame_start, except the first frame_start after reset. So it reads 0 during frame 0 and 1 during frame 1. It wraps modulo 256.
- Period: line = 800 clocks, frame = 420000 clocks (≈59.94 Hz at 25.175 MHz).
- No other inputs; behaviour is fully deterministic from reset.

Test Plan:
1. Hold rst=0 for 5 clocks, then release.
   -> During reset: pixel_x=799, pixel_y=524, video_on=0, hsync=vsync=1.
   -> First post-release cycle: (0,0), video_on=1, frame_start=1, frame_count=0.
2. Run one line from release.
   -> video_on=1 for cycles 0..639, 0 for 640..799.
   -> hsync=0 for exactly 96 clocks, covering cycles where pixel_x was 656..751, seen one clock later (SYNC_DELAY=1).
   -> pixel_x wraps 799->0 while pixel_y goes 0->1.
3. Run two full frames.
   -> frame_start pulses spaced exactly 420000 clocks apart.
   -> vblank_start is asserted once per frame at (0,480), 384000 clocks after frame_start.
   -> vsync=0 for 1600 clocks spanning lines 490-491.
   -> frame_count reads 1 after the second frame_start.
4. Assert rst=0 for one clock at (pixel_x=300, pixel_y=200), then release.
   -> Next cycle is (0,0) with frame_start=1.
   -> frame_count=0; no residual sync pulse from the delay stages.
5. Build with SYNC_DELAY=0 and SYNC_DELAY=3.
   -> hsync falling edge appears on the same cycle as pixel_x=656 (delay 0), or 3 clocks after it (delay 3).
   -> video_on timing is unchanged in both builds.
6. Run 256 frames (or force-check via a shortened-parameter build: H_VIDEO=8, H_FP=H_SYNC=H_BP=2, V_VIDEO=4, V_FP=V_SYNC=V_BP=1).
   -> frame_count wraps 255->0.
   -> Totals become 14x7, and all pulse positions scale accordingly.
